// File: rtl/cpu_mem_arbiter_if.sv
// rtl/cpu_mem_arbiter_if.sv - port bundle between the datapath, the arbiter and physical memory
//
// Port summary:
//   port A (fetch)  : read_a, address_a -> rdata_a, resp_a
//   port B (data)   : read_b, write, wmask, address_b, wdata -> rdata_b, resp_b
//   physical memory : pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask <- pmem_rdata, pmem_resp
//   master modport  : datapath/memory environment side
//   slave modport   : arbiter side
interface cpu_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                  read_a;
  logic [DATA_WIDTH-1:0] address_a;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic                  resp_a;

  logic                  read_b;
  logic                  write;
  logic [MASK_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] address_b;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata_b;
  logic                  resp_b;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [DATA_WIDTH-1:0] pmem_address;
  logic [DATA_WIDTH-1:0] pmem_wdata;
  logic [MASK_WIDTH-1:0] pmem_wmask;
  logic [DATA_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport master (
    output read_a, address_a, read_b, write, wmask, address_b, wdata, pmem_rdata, pmem_resp,
    input  rdata_a, resp_a, rdata_b, resp_b,
           pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask
  );

  modport slave (
    input  read_a, address_a, read_b, write, wmask, address_b, wdata, pmem_rdata, pmem_resp,
    output rdata_a, resp_a, rdata_b, resp_b,
           pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - round-robin arbiter of fetch and data ports onto one physical memory
//
// Port summary:
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-high reset
//   bus : cpu_mem_arbiter_if.slave carrying port A, port B and the physical memory interface
module cpu_mem_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  cpu_mem_arbiter_if.slave  bus
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, BUSY_A, BUSY_B, RESP_A, RESP_B} state_e;
  typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_e;

  state_e                state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
  logic                  op_write_q, op_write_d;
  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;

  logic pend_a;
  logic pend_b;
  logic grant_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_A;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      op_write_q   <= 1'b0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      op_write_q   <= op_write_d;
      rdata_a_q    <= rdata_a_d;
      rdata_b_q    <= rdata_b_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    op_write_d   = op_write_q;
    rdata_a_d    = rdata_a_q;
    rdata_b_d    = rdata_b_q;

    pend_a  = bus.read_a;
    pend_b  = bus.read_b | bus.write;
    // On a conflict, B wins unless it was the last port served.
    grant_b = pend_b && (!pend_a || (last_grant_q == GRANT_A));

    case (state_q)
      IDLE: begin
        if (grant_b) begin
          state_d      = BUSY_B;
          last_grant_d = GRANT_B;
          addr_d       = bus.address_b;
          // write dominates when read_b and write arrive together
          op_write_d   = bus.write;
          wdata_d      = bus.write ? bus.wdata : '0;
          wmask_d      = bus.write ? bus.wmask : '0;
        end else if (pend_a) begin
          state_d      = BUSY_A;
          last_grant_d = GRANT_A;
          addr_d       = bus.address_a;
          op_write_d   = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
        end
      end
      BUSY_A: begin
        if (bus.pmem_resp) begin
          rdata_a_d = bus.pmem_rdata;
          state_d   = RESP_A;
        end
      end
      BUSY_B: begin
        if (bus.pmem_resp) begin
          // a store completes without disturbing the last load result
          if (!op_write_q) begin
            rdata_b_d = bus.pmem_rdata;
          end
          state_d = RESP_B;
        end
      end
      RESP_A, RESP_B: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  // Every output comes from state or latched request registers only.
  assign bus.pmem_read    = (state_q == BUSY_A) || ((state_q == BUSY_B) && !op_write_q);
  assign bus.pmem_write   = (state_q == BUSY_B) && op_write_q;
  assign bus.pmem_address = addr_q & {{(DATA_WIDTH-2){1'b1}}, 2'b00};
  assign bus.pmem_wdata   = wdata_q;
  assign bus.pmem_wmask   = wmask_q;
  assign bus.resp_a       = (state_q == RESP_A);
  assign bus.resp_b       = (state_q == RESP_B);
  assign bus.rdata_a      = rdata_a_q;
  assign bus.rdata_b      = rdata_b_q;

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Arbitrates the datapath's two memory ports onto a single physical memory interface: instruction fetch (port A) and data load/store (port B). It sits directly downstream of the pipelined datapath's memory ports. Each request is latched and issued to physical memory, and the result is returned with a one-cycle response pulse that the pipeline uses to stall or advance. Both requests may arrive together; the arbiter grants them round-robin.

## Interface
- DATA_WIDTH, 32: width of address, read data and write data on all ports; wmask width is DATA_WIDTH/8.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- read_a  in  1  instruction read request, level; held until resp_a.
- address_a  in  32  instruction address.
- rdata_a  out  32  instruction read data; valid while resp_a=1.
- resp_a  out  1  one-cycle completion pulse for port A.
- read_b  in  1  data read request, level; held until resp_b.
- write  in  1  data write request, level; held until resp_b.
- wmask  in  4  byte enables for write.
- address_b  in  32  data address.
- wdata  in  32  write data.
- rdata_b  out  32  data read data; valid while resp_b=1 after a read.
- resp_b  out  1  one-cycle completion pulse for port B.
- pmem_read  out  1  physical read strobe, level until pmem_resp.
- pmem_write  out  1  physical write strobe, level until pmem_resp.
- pmem_address  out  32  word-aligned address {addr[31:2],2'b00}.
- pmem_wdata  out  32  latched write data.
- pmem_wmask  out  4  latched byte enables; 4'b0000 on reads.
- pmem_rdata  in  32  physical read data; valid with pmem_resp.
- pmem_resp  in  1  physical completion, one cycle.

## Operation
- FSM states: IDLE, BUSY_A, BUSY_B, RESP_A, RESP_B.
- IDLE: port B is pending if read_b|write, port A if read_a.
  - Only one port pending: grant that port.
  - Both pending: grant the port not in last_grant.
  - On grant, latch address, op, wdata and wmask into request registers, set last_grant, and go to BUSY_x.
- BUSY_x: pmem_read or pmem_write is driven from the latched op.
  - Port inputs are ignored, so requester changes or withdrawals have no effect.
  - On pmem_resp, capture pmem_rdata into the port's rdata register and go to RESP_x.
- RESP_x: resp_x=1 for exactly this cycle; then IDLE unconditionally.
- Write on port B: resp_b pulses; rdata_b keeps its previous value.
- read_b and write both asserted: treated as a write; pmem_read stays 0.
- pmem_resp in IDLE or RESP_x: ignored.
- The arbiter never issues pmem_read and pmem_write together.

## Timing
- Reset values:
  - state=IDLE, last_grant=A, so B wins the first conflict.
  - All outputs 0: resp_a, resp_b, pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask, rdata_a, rdata_b.
- All outputs are registered or decoded from state/latched registers; there is no combinational path from port inputs to pmem outputs.
- Latency, request at IDLE cycle 0:
  - pmem strobe asserted from cycle 1.
  - If pmem_resp arrives in cycle k≥1, resp_x and rdata_x are valid in cycle k+1.
  - IDLE again at k+2.
- Minimum back-to-back spacing is 3 cycles per accepted request.
- The requester must drop or change its request in the RESP_x cycle. A request still asserted in IDLE is treated as a new request.
- Reset asserted mid-transaction: immediately IDLE with all outputs 0. The aborted transaction gets no resp, and a late pmem_resp is ignored.

## Test plan
- Single fetch:
  - Stimulus: read_a=1, address_a=0x60, pmem_resp one cycle after the strobe with pmem_rdata=0x00000013.
  - Required: pmem_address=0x60 with pmem_read=1 in cycles 1-2; resp_a=1 and rdata_a=0x13 in cycle 3 only.
- Conflict rotation:
  - Stimulus: read_a and read_b held high continuously from reset.
  - Required grant order B, A, B, A; never two consecutive grants to the same port while the other is pending.
- Store:
  - Stimulus: write=1, address_b=0x1003, wmask=4'b1000, wdata=0xAB000000.
  - Required: pmem_write=1, pmem_address=0x1000, pmem_wmask=4'b1000, pmem_read=0; resp_b pulses; rdata_b unchanged.
- Request withdrawal:
  - Stimulus: drop read_a and change address_a while in BUSY_A.
  - Required: pmem_address stays at the original value; transaction completes with resp_a.
- Async reset:
  - Stimulus: assert rst mid-BUSY_B, release, then pulse pmem_resp.
  - Required: all outputs 0 immediately; no resp_b; state IDLE.
- Read+write conflict on B:
  - Stimulus: read_b=1 and write=1 simultaneously.
  - Required: only pmem_write asserted; single resp_b.
